handshake_eager_fork: RTL and testbench

//  Eager fork: replicates one elastic token (data + valid/ready) onto NUM_OUTPUTS

---
 rtl/handshake_eager_fork.sv | 45 ++++
 tb/tb_handshake_eager_fork.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/handshake_eager_fork.sv
// Eager fork: broadcasts one elastic token to NUM_OUTPUTS consumers, each taking it
// independently; the input is released once every consumer has taken it.
module handshake_eager_fork #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_OUTPUTS = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             ins,
  input  logic                              ins_valid,
  output logic                              ins_ready,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] outs,
  output logic [NUM_OUTPUTS-1:0]            outs_valid,
  input  logic [NUM_OUTPUTS-1:0]            outs_ready
);

  // One bit per output: 1 once that consumer has taken the current token.
  logic [NUM_OUTPUTS-1:0] sent;
  logic [NUM_OUTPUTS-1:0] sent_next;
  logic [NUM_OUTPUTS-1:0] fire;
  logic                   xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      sent <= '0;
    end else begin
      sent <= sent_next;
    end
  end

  // Handshakes are gated off during reset; ins_ready never feeds outs_valid.
  always_comb begin
    outs       = {NUM_OUTPUTS{ins}};
    outs_valid = '0;
    ins_ready  = 1'b0;
    if (!rst) begin
      outs_valid = {NUM_OUTPUTS{ins_valid}} & ~sent;
      ins_ready  = &(outs_ready | sent);
    end
    fire      = outs_valid & outs_ready;
    xfer      = ins_valid & ins_ready;
    sent_next = xfer ? '0 : (sent | fire);
  end

endmodule

// File: tb/tb_handshake_eager_fork.sv
// Directed bench for handshake_eager_fork (33-bit data, 3 outputs): per-cycle
// vector table plus a scoreboarded back-to-back token stream.
module tb_handshake_eager_fork;

  localparam int unsigned DW = 33;
  localparam int unsigned NO = 3;

  logic                 clk;
  logic                 rst;
  logic [DW-1:0]        ins;
  logic                 ins_valid;
  logic                 ins_ready;
  logic [NO*DW-1:0]     outs;
  logic [NO-1:0]        outs_valid;
  logic [NO-1:0]        outs_ready;

  int checks;
  int failures;

  handshake_eager_fork #(.DATA_WIDTH(DW), .NUM_OUTPUTS(NO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [DW-1:0] ins;
    logic          valid;
    logic [NO-1:0] rdy;
    logic [NO-1:0] exp_ov;
    logic          exp_ir;
  } vec_t;

  vec_t tbl[80];
  int   n_vec;

  task automatic add(input logic r, input logic [DW-1:0] d, input logic v,
                     input logic [NO-1:0] rd, input logic [NO-1:0] ov, input logic ir);
    tbl[n_vec] = '{r, d, v, rd, ov, ir};
    n_vec++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] tok_a;
  logic [DW-1:0] tok_b;
  int            exp_idx[NO];
  int            tok;
  int            cyc;

  initial begin
    checks     = 0;
    failures   = 0;
    n_vec      = 0;
    rst        = 1'b1;
    ins        = '0;
    ins_valid  = 1'b0;
    outs_ready = '0;
    tok_a      = 33'h0FBB9C1F1;
    tok_b      = 33'h1_2345_6789;

    // reset held two cycles with a valid token waiting
    add(1, tok_a, 1, 3'b111, 3'b000, 0);
    add(1, tok_a, 1, 3'b111, 3'b000, 0);
    add(0, tok_a, 1, 3'b000, 3'b111, 0);
    // broadcast: all ready, token retires in one cycle, sent stays clear
    add(0, tok_a, 1, 3'b111, 3'b111, 1);
    add(0, tok_a, 1, 3'b000, 3'b111, 0);
    // staggered takes
    add(0, tok_b, 1, 3'b001, 3'b111, 0);
    add(0, tok_b, 1, 3'b100, 3'b110, 0);
    add(0, tok_b, 1, 3'b010, 3'b010, 1);
    add(0, tok_a, 1, 3'b000, 3'b111, 0);
    // valid dropped mid-token: sent held, ready toggling on a sent output is ignored
    add(0, tok_a, 1, 3'b001, 3'b111, 0);
    add(0, tok_a, 0, 3'b111, 3'b000, 1);
    add(0, tok_a, 1, 3'b000, 3'b110, 0);
    add(0, tok_a, 1, 3'b001, 3'b110, 0);
    add(0, tok_a, 1, 3'b000, 3'b110, 0);
    add(0, tok_a, 1, 3'b110, 3'b110, 1);
    // stall for 10 cycles
    for (int k = 0; k < 10; k++) add(0, tok_b, 1, 3'b000, 3'b111, 0);
    // mid-token reset discards output 0's take
    add(0, tok_b, 1, 3'b001, 3'b111, 0);
    add(0, tok_b, 1, 3'b000, 3'b110, 0);
    add(1, tok_b, 1, 3'b000, 3'b000, 0);
    add(0, tok_b, 1, 3'b000, 3'b111, 0);
    add(0, tok_b, 1, 3'b111, 3'b111, 1);

    for (int i = 0; i < n_vec; i++) begin
      @(negedge clk);
      rst        = tbl[i].rst;
      ins        = tbl[i].ins;
      ins_valid  = tbl[i].valid;
      outs_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_outs_valid", i), 64'(outs_valid), 64'(tbl[i].exp_ov));
      chk($sformatf("v%0d_ins_ready", i), 64'(ins_ready), 64'(tbl[i].exp_ir));
      for (int j = 0; j < int'(NO); j++)
        chk($sformatf("v%0d_outs%0d", i, j), 64'(outs[j*DW +: DW]), 64'(tbl[i].ins));
    end

    // back-to-back tokens 0..7 with random per-output ready
    tok = 0;
    cyc = 0;
    for (int j = 0; j < int'(NO); j++) exp_idx[j] = 0;
    while (tok < 8 && cyc < 300) begin
      @(negedge clk);
      ins        = DW'(tok);
      ins_valid  = 1'b1;
      outs_ready = NO'($urandom_range(0, 7));
      #1;
      for (int j = 0; j < int'(NO); j++) begin
        if (outs_valid[j] && outs_ready[j]) begin
          chk($sformatf("t4_out%0d_data", j), 64'(outs[j*DW +: DW]), 64'(exp_idx[j]));
          exp_idx[j]++;
        end
      end
      if (ins_ready) tok++;
      cyc++;
    end
    @(negedge clk);
    ins_valid  = 1'b0;
    outs_ready = '0;
    chk("t4_tokens_retired", 64'(tok), 64'd8);
    for (int j = 0; j < int'(NO); j++)
      chk($sformatf("t4_out%0d_count", j), 64'(exp_idx[j]), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
